// File: rtl/bingo_pkg.sv
// rtl/bingo_pkg.sv - shared cell, error and FSM encodings for the BINGO board
package bingo_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] PL_A  = 2'b01;
  localparam logic [1:0] PL_B  = 2'b10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_OCC   = 2'b10;
  localparam logic [1:0] ERR_TURN  = 2'b11;

  localparam int NUM_CELLS = 9;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PL_A) ? PL_B : PL_A;
  endfunction

endpackage

// File: rtl/bingo_move_check.sv
// rtl/bingo_move_check.sv - combinational move legality check and cell decode
module bingo_move_check (
  input  logic [1:0]  row,
  input  logic [1:0]  col,
  input  logic [1:0]  player,
  input  logic [1:0]  turn,
  input  logic [17:0] board,
  output logic        legal,
  output logic [1:0]  err_code,
  output logic [8:0]  cell_sel
);
  import bingo_pkg::*;

  logic       range_bad;
  logic       occupied;
  logic [3:0] idx;

  always_comb begin
    range_bad = (row == 2'd0) || (col == 2'd0);
    idx       = ({2'b00, row} - 4'd1) * 4'd3 + ({2'b00, col} - 4'd1);
    cell_sel  = range_bad ? 9'd0 : (9'd1 << idx);
    occupied  = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_sel[i] && (board[2*i +: 2] != EMPTY)) occupied = 1'b1;
    end

    // Range beats turn beats occupancy when several faults coincide.
    legal    = 1'b0;
    err_code = ERR_NONE;
    if (range_bad)             err_code = ERR_RANGE;
    else if (player != turn)   err_code = ERR_TURN;
    else if (occupied)         err_code = ERR_OCC;
    else                       legal    = 1'b1;
  end

endmodule

// File: rtl/bingo_board_writer.sv
// rtl/bingo_board_writer.sv - validated move writer driving the 3x3 board to the scorer
module bingo_board_writer #(
  parameter int         SETTLE_CYC   = 1,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLEAR,
  input  logic       MOVE_VALID,
  output logic       MOVE_READY,
  input  logic [1:0] MOVE_ROW,
  input  logic [1:0] MOVE_COL,
  input  logic [1:0] MOVE_PLAYER,
  output logic [1:0] IN_11,
  output logic [1:0] IN_12,
  output logic [1:0] IN_13,
  output logic [1:0] IN_21,
  output logic [1:0] IN_22,
  output logic [1:0] IN_23,
  output logic [1:0] IN_31,
  output logic [1:0] IN_32,
  output logic [1:0] IN_33,
  output logic [1:0] TURN,
  output logic [3:0] MOVE_CNT,
  output logic       FULL,
  output logic       ACK_OK,
  output logic       ACK_ERR,
  output logic [1:0] ERR_CODE
);
  import bingo_pkg::*;

  state_t      state, state_next;
  logic [2:0]  settle_cnt, settle_next;
  logic [17:0] board, board_wr;
  logic [1:0]  turn;
  logic [3:0]  move_cnt;
  logic        ack_ok, ack_err;
  logic [1:0]  err_code;

  logic        chk_legal;
  logic [1:0]  chk_err;
  logic [8:0]  cell_sel;
  logic        take, accept;

  bingo_move_check u_check (
    .row      (MOVE_ROW),
    .col      (MOVE_COL),
    .player   (MOVE_PLAYER),
    .turn     (turn),
    .board    (board),
    .legal    (chk_legal),
    .err_code (chk_err),
    .cell_sel (cell_sel)
  );

  assign MOVE_READY = (state == ST_PLAY) && !CLEAR;
  assign take       = MOVE_VALID && MOVE_READY;
  assign accept     = take && chk_legal;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_PLAY;
      settle_cnt <= 3'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    if (CLEAR) begin
      state_next  = ST_PLAY;
      settle_next = 3'd0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (accept) begin
            if (move_cnt == 4'd8) begin
              state_next = ST_DONE;
            end else begin
              state_next  = ST_SETTLE;
              settle_next = 3'(SETTLE_CYC);
            end
          end
        end
        // Leaving at a count of 1 keeps READY low for exactly SETTLE_CYC cycles.
        ST_SETTLE: begin
          if (settle_cnt <= 3'd1) begin
            state_next  = ST_PLAY;
            settle_next = 3'd0;
          end else begin
            settle_next = settle_cnt - 3'd1;
          end
        end
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    board_wr = board;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cell_sel[i]) board_wr[2*i +: 2] = MOVE_PLAYER;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      board    <= '0;
      turn     <= FIRST_PLAYER;
      move_cnt <= 4'd0;
      ack_ok   <= 1'b0;
      ack_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      ack_ok  <= 1'b0;
      ack_err <= 1'b0;
      if (CLEAR) begin
        board    <= '0;
        turn     <= FIRST_PLAYER;
        move_cnt <= 4'd0;
        err_code <= ERR_NONE;
      end else if (take) begin
        if (chk_legal) begin
          board    <= board_wr;
          turn     <= other_player(turn);
          move_cnt <= move_cnt + 4'd1;
          ack_ok   <= 1'b1;
          err_code <= ERR_NONE;
        end else begin
          ack_err  <= 1'b1;
          err_code <= chk_err;
        end
      end
    end
  end

  assign IN_11    = board[1:0];
  assign IN_12    = board[3:2];
  assign IN_13    = board[5:4];
  assign IN_21    = board[7:6];
  assign IN_22    = board[9:8];
  assign IN_23    = board[11:10];
  assign IN_31    = board[13:12];
  assign IN_32    = board[15:14];
  assign IN_33    = board[17:16];
  assign TURN     = turn;
  assign MOVE_CNT = move_cnt;
  assign FULL     = (state == ST_DONE);
  assign ACK_OK   = ack_ok;
  assign ACK_ERR  = ack_err;
  assign ERR_CODE = err_code;

endmodule

// File: tb/tb_bingo_board_writer.sv
// tb/tb_bingo_board_writer.sv - directed scoreboard bench for bingo_board_writer
module tb_bingo_board_writer;
  import bingo_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                  RST_N;
  logic [1:0]            clear, valid;
  logic [1:0][1:0]       row, col, pl;
  logic [1:0]            ready, full, ack_ok, ack_err;
  logic [1:0][1:0]       turn, err;
  logic [1:0][3:0]       cnt;
  logic [1:0][17:0]      brd;

  // Instance 0 settles for 1 cycle, instance 1 for 3 cycles.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bingo_board_writer #(.SETTLE_CYC((g == 0) ? 1 : 3), .FIRST_PLAYER(2'b01)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .CLEAR(clear[g]),
      .MOVE_VALID(valid[g]), .MOVE_READY(ready[g]),
      .MOVE_ROW(row[g]), .MOVE_COL(col[g]), .MOVE_PLAYER(pl[g]),
      .IN_11(brd[g][1:0]),   .IN_12(brd[g][3:2]),   .IN_13(brd[g][5:4]),
      .IN_21(brd[g][7:6]),   .IN_22(brd[g][9:8]),   .IN_23(brd[g][11:10]),
      .IN_31(brd[g][13:12]), .IN_32(brd[g][15:14]), .IN_33(brd[g][17:16]),
      .TURN(turn[g]), .MOVE_CNT(cnt[g]), .FULL(full[g]),
      .ACK_OK(ack_ok[g]), .ACK_ERR(ack_err[g]), .ERR_CODE(err[g])
    );
  end

  typedef struct {
    logic        ok;
    logic [1:0]  err;
    logic [1:0]  turn;
    logic [3:0]  cnt;
    logic [17:0] board;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] mcell [2][9];
  logic [1:0] mturn [2];
  int         mcnt  [2];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 9; i++) mcell[d][i] = EMPTY;
    mturn[d] = PL_A;
    mcnt[d]  = 0;
  endtask

  function automatic logic [17:0] mpack(input int d);
    logic [17:0] v;
    for (int i = 0; i < 9; i++) v[2*i +: 2] = mcell[d][i];
    return v;
  endfunction

  task automatic do_move(input int d, input logic [1:0] r, input logic [1:0] c, input logic [1:0] p);
    int   n;
    int   idx;
    exp_t e;
    exp_t got;
    n = 0;
    row[d] = r; col[d] = c; pl[d] = p; valid[d] = 1'b1;
    while (!ready[d] && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", {31'd0, ready[d]}, 32'd1);
    idx   = (int'(r) - 1) * 3 + (int'(c) - 1);
    e.ok  = 1'b0;
    e.err = ERR_NONE;
    if (r == 2'd0 || c == 2'd0)        e.err = ERR_RANGE;
    else if (p != mturn[d])            e.err = ERR_TURN;
    else if (mcell[d][idx] != EMPTY)   e.err = ERR_OCC;
    else begin
      e.ok = 1'b1;
      mcell[d][idx] = p;
      mturn[d] = (mturn[d] == PL_A) ? PL_B : PL_A;
      mcnt[d]++;
    end
    e.turn  = mturn[d];
    e.cnt   = 4'(mcnt[d]);
    e.board = mpack(d);
    sbq.push_back(e);
    step();
    valid[d] = 1'b0;
    got = sbq.pop_front();
    chk("ack_ok", {31'd0, ack_ok[d]}, {31'd0, got.ok});
    chk("ack_err", {31'd0, ack_err[d]}, {31'd0, !got.ok});
    if (!got.ok) chk("err_code", {30'd0, err[d]}, {30'd0, got.err});
    chk("turn", {30'd0, turn[d]}, {30'd0, got.turn});
    chk("move_cnt", {28'd0, cnt[d]}, {28'd0, got.cnt});
    chk("board", {14'd0, brd[d]}, {14'd0, got.board});
  endtask

  initial begin
    clear = '0; valid = '0; row = '0; col = '0; pl = '0;
    model_reset(0);
    model_reset(1);
    RST_N = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;
    step();

    for (int d = 0; d < 2; d++) begin
      chk("rst_board", {14'd0, brd[d]}, 32'd0);
      chk("rst_turn", {30'd0, turn[d]}, 32'd1);
      chk("rst_ready", {31'd0, ready[d]}, 32'd1);
      chk("rst_cnt", {28'd0, cnt[d]}, 32'd0);
      chk("rst_full", {31'd0, full[d]}, 32'd0);
      chk("rst_acks", {30'd0, ack_ok[d], ack_err[d]}, 32'd0);
      chk("rst_err", {30'd0, err[d]}, 32'd0);
    end

    do_move(0, 2'd2, 2'd2, PL_A);
    chk("settle1_ready_low", {31'd0, ready[0]}, 32'd0);
    step();
    chk("settle1_ready_high", {31'd0, ready[0]}, 32'd1);
    chk("ack_ok_single", {31'd0, ack_ok[0]}, 32'd0);

    do_move(0, 2'd2, 2'd2, PL_B);
    step();
    chk("ack_err_single", {31'd0, ack_err[0]}, 32'd0);
    chk("err_code_held", {30'd0, err[0]}, {30'd0, ERR_OCC});
    do_move(0, 2'd0, 2'd1, PL_B);
    do_move(0, 2'd1, 2'd1, PL_A);
    chk("turn_after_rejects", {30'd0, turn[0]}, {30'd0, PL_B});

    do_move(0, 2'd1, 2'd1, PL_B);
    do_move(0, 2'd1, 2'd2, PL_A);
    do_move(0, 2'd1, 2'd3, PL_B);
    do_move(0, 2'd2, 2'd1, PL_A);
    do_move(0, 2'd2, 2'd3, PL_B);
    do_move(0, 2'd3, 2'd1, PL_A);
    do_move(0, 2'd3, 2'd2, PL_B);
    do_move(0, 2'd3, 2'd3, PL_A);
    chk("done_full", {31'd0, full[0]}, 32'd1);
    chk("done_cnt", {28'd0, cnt[0]}, 32'd9);
    chk("done_ready", {31'd0, ready[0]}, 32'd0);
    row[0] = 2'd1; col[0] = 2'd1; pl[0] = PL_B; valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("done_no_ack", {30'd0, ack_ok[0], ack_err[0]}, 32'd0);
    end
    valid[0] = 1'b0;

    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    #1;
    model_reset(0);
    chk("clr_done_full", {31'd0, full[0]}, 32'd0);
    chk("clr_done_cnt", {28'd0, cnt[0]}, 32'd0);
    chk("clr_done_ready", {31'd0, ready[0]}, 32'd1);

    do_move(0, 2'd3, 2'd3, PL_A);
    do_move(0, 2'd2, 2'd1, PL_B);
    step();
    row[0] = 2'd1; col[0] = 2'd1; pl[0] = PL_A; valid[0] = 1'b1; clear[0] = 1'b1;
    #1;
    chk("clr_ready_low", {31'd0, ready[0]}, 32'd0);
    step();
    clear[0] = 1'b0; valid[0] = 1'b0;
    model_reset(0);
    chk("clr_no_ack", {30'd0, ack_ok[0], ack_err[0]}, 32'd0);
    chk("clr_board", {14'd0, brd[0]}, 32'd0);
    chk("clr_turn", {30'd0, turn[0]}, 32'd1);
    chk("clr_cnt", {28'd0, cnt[0]}, 32'd0);

    do_move(1, 2'd1, 2'd1, PL_A);
    chk("settle3_c1", {31'd0, ready[1]}, 32'd0);
    step();
    chk("settle3_c2", {31'd0, ready[1]}, 32'd0);
    step();
    chk("settle3_c3", {31'd0, ready[1]}, 32'd0);
    step();
    chk("settle3_end", {31'd0, ready[1]}, 32'd1);

    do_move(1, 2'd1, 2'd2, PL_B);
    clear[1] = 1'b1;
    step();
    clear[1] = 1'b0;
    #1;
    model_reset(1);
    chk("clr_settle_ready", {31'd0, ready[1]}, 32'd1);
    chk("clr_settle_cnt", {28'd0, cnt[1]}, 32'd0);
    chk("clr_settle_board", {14'd0, brd[1]}, 32'd0);

    do_move(1, 2'd3, 2'd3, PL_A);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_board", {14'd0, brd[1]}, 32'd0);
    chk("arst_cnt", {28'd0, cnt[1]}, 32'd0);
    chk("arst_turn", {30'd0, turn[1]}, 32'd1);
    chk("arst_ack_ok", {31'd0, ack_ok[1]}, 32'd0);
    chk("arst_full", {31'd0, full[1]}, 32'd0);
    model_reset(0);
    model_reset(1);
    #1;
    RST_N = 1'b1;
    step();
    chk("arst_ready", {31'd0, ready[1]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
